mips_lsu: RTL and testbench
===========================

// Module: mips_lsu
// PURPOSE
//  Load/store unit: the initiator side of the data-memory port in the MIPS datapath.
//  Takes byte-addressed load/store requests from the core.
//  Drives the word-addressed, single-port, 1-cycle-read-latency data memory.
//  Does read-modify-write for byte/half stores, lane extraction and sign-extension for loads,
//  and range/alignment checking. One request in flight; returns response via valid/ready.
// PARAMETERS
//  MEM_WORDS  128  number of 32-bit words in data memory; word index >= MEM_WORDS is an error
//  ADDR_W     8    width of mem_addr (word index)
// PORTS
//  clk         in   1       clock, all state updates on rising edge
//  rst_n       in   1       asynchronous active-low reset
//  req_valid   in   1       core presents a request
//  req_ready   out  1       LSU can accept (state IDLE)
//  req_we      in   1       1=store, 0=load
//  req_size    in   2       00=byte, 01=half, 10=word, 11=illegal (error)
//  req_signed  in   1       loads only: 1=sign-extend, 0=zero-extend
//  req_addr    in   32      byte address
//  req_wdata   in   32      store data, right-aligned (byte in [7:0], half in [15:0])
//  resp_valid  out  1       response available
//  resp_ready  in   1       core accepts response
//  resp_rdata  out  32      load result (0 for stores and errors)
//  resp_err    out  1       misaligned, size=11 or out-of-range; memory untouched
//  mem_we      out  1       memory write strobe (1=write, 0=read)
//  mem_addr    out  ADDR_W  word index = req_addr[ADDR_W+1:2]
//  mem_wd      out  32      memory write data
//  mem_rd      in   32      memory read data, valid the cycle after a read is issued
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; req_ready=1 after release.
//   resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
//  Handshake: request accepted on clk edge with req_valid&req_ready.
//   Response completes on resp_valid&resp_ready. resp_* stable while resp_valid=1 and resp_ready=0.
//  Error check at accept:
//   misaligned = (size=01 & addr[0]) | (size=10 & addr[1:0]!=0);
//   out-of-range = req_addr[31:2] >= MEM_WORDS; size=11 is also an error.
//   On error: go straight to RESP, resp_err=1; mem_we never asserts.
//  FSM (request fields latched at accept):
//   IDLE   req_ready=1; accept -> ISSUE, or -> RESP on error.
//   ISSUE  mem_addr=word index.
//          Word store: mem_we=1, mem_wd=wdata -> RESP.
//          Otherwise: mem_we=0 (read) -> WAIT.
//   WAIT   mem_rd valid.
//          Load: extract lane (little-endian: addr[1:0]=0 -> bits[7:0]), extend -> RESP.
//          Byte/half store: merge wdata into lane of mem_rd, register -> WRITE.
//   WRITE  mem_we=1, mem_wd=merged word, same mem_addr -> RESP.
//   RESP   resp_valid=1; on resp_ready -> IDLE. No back-to-back accept in RESP cycle.
//  Latency, accept edge T to resp_valid:
//   error T+1; word store T+2; load T+3; byte/half store T+4.
//  mem_we: high exactly one cycle per store, zero cycles per load/error.
//   Low in every state except ISSUE(word store) and WRITE.
//  mem_addr/mem_wd are registered; they hold last value in IDLE/RESP (memory read is harmless).
//  Half lanes: addr[1]=0 -> [15:0], addr[1]=1 -> [31:16].
//  Reset mid-operation: aborts immediately, no further mem_we, no response.
//   A write already strobed is not undone.
// TESTING
//  1 Store word 0xDEADBEEF @0x10, load word @0x10
//    -> mem_we 1 cycle with addr 4; load resp_rdata=0xDEADBEEF at T+3, err=0.
//  2 Mem word 4 = 0x11223344; store byte 0xAA @0x12
//    -> read then write 0x11AA3344; load byte signed @0x12 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
//  3 Store half 0xBEEF @0x1E over 0x00000000
//    -> word 7 = 0xBEEF0000; load half signed @0x1E -> 0xFFFFBEEF.
//  4 Errors: load word @0x3, store half @0x5, store word @0x200 (index 128), size=11
//    -> resp_err=1 at T+1, mem_we never 1, resp_rdata=0.
//  5 Hold resp_ready=0 for 5 cycles after load
//    -> resp_valid/rdata stable, req_ready=0; a new req_valid is not accepted until after completion.
//  6 Assert rst_n=0 in WAIT of byte store
//    -> all outputs 0 asynchronously, no WRITE strobe, memory word unchanged; next request works.

Source files
------------

// File: rtl/mips_lsu.sv
// Load/store unit: initiator side of the data-memory port.
// Accepts one byte-addressed request at a time. Byte and half stores become a
// read-modify-write of the containing word. Loads are lane-extracted and extended.
module mips_lsu #(
   parameter int unsigned MEM_WORDS = 128,
   parameter int unsigned ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   input  logic [31:0]       mem_rd
);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StWrite, StResp} state_e;

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                sgn_q, sgn_d;
   logic [1:0]          off_q, off_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [31:0]         mem_wd_q, mem_wd_d;
   logic [31:0]         rdata_q, rdata_d;
   logic                err_q, err_d;

   logic                misaligned, out_of_range, req_err, accept;
   logic [31:0]         load_val, merged;

   assign req_ready  = (state_q == StIdle);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wd     = mem_wd_q;

   assign accept       = req_valid & req_ready;
   assign misaligned   = ((req_size == 2'b01) & req_addr[0]) |
                         ((req_size == 2'b10) & (req_addr[1:0] != 2'b00));
   assign out_of_range = ({2'b00, req_addr[31:2]} >= MEM_WORDS);
   assign req_err      = misaligned | out_of_range | (req_size == 2'b11);

   // Lane extraction for loads and lane merge for byte/half stores, little-endian.
   always_comb begin
      load_val = mem_rd;
      merged   = mem_rd;
      unique case (size_q)
         2'b00: begin
            unique case (off_q)
               2'd0: begin
                  load_val     = {{24{sgn_q & mem_rd[7]}}, mem_rd[7:0]};
                  merged[7:0]  = wdata_q[7:0];
               end
               2'd1: begin
                  load_val     = {{24{sgn_q & mem_rd[15]}}, mem_rd[15:8]};
                  merged[15:8] = wdata_q[7:0];
               end
               2'd2: begin
                  load_val      = {{24{sgn_q & mem_rd[23]}}, mem_rd[23:16]};
                  merged[23:16] = wdata_q[7:0];
               end
               default: begin
                  load_val      = {{24{sgn_q & mem_rd[31]}}, mem_rd[31:24]};
                  merged[31:24] = wdata_q[7:0];
               end
            endcase
         end
         2'b01: begin
            if (off_q[1]) begin
               load_val      = {{16{sgn_q & mem_rd[31]}}, mem_rd[31:16]};
               merged[31:16] = wdata_q;
            end else begin
               load_val      = {{16{sgn_q & mem_rd[15]}}, mem_rd[15:0]};
               merged[15:0]  = wdata_q;
            end
         end
         default: ;
      endcase
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      sgn_d      = sgn_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      mem_we_d   = mem_we_q;
      mem_addr_d = mem_addr_q;
      mem_wd_d   = mem_wd_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               we_d    = req_we;
               size_d  = req_size;
               sgn_d   = req_signed;
               off_d   = req_addr[1:0];
               wdata_d = req_wdata[15:0];
               rdata_d = '0;
               if (req_err) begin
                  // Memory port left untouched on error.
                  err_d   = 1'b1;
                  state_d = StResp;
               end else begin
                  err_d      = 1'b0;
                  mem_addr_d = req_addr[ADDR_W+1:2];
                  mem_wd_d   = req_wdata;
                  mem_we_d   = req_we & (req_size == 2'b10);
                  state_d    = StIssue;
               end
            end
         end
         StIssue: begin
            mem_we_d = 1'b0;
            state_d  = (we_q && size_q == 2'b10) ? StResp : StWait;
         end
         StWait: begin
            if (we_q) begin
               mem_wd_d = merged;
               mem_we_d = 1'b1;
               state_d  = StWrite;
            end else begin
               rdata_d = load_val;
               state_d = StResp;
            end
         end
         StWrite: begin
            mem_we_d = 1'b0;
            state_d  = StResp;
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         we_q       <= 1'b0;
         size_q     <= 2'b00;
         sgn_q      <= 1'b0;
         off_q      <= 2'b00;
         wdata_q    <= '0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_wd_q   <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         we_q       <= we_d;
         size_q     <= size_d;
         sgn_q      <= sgn_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_wd_q   <= mem_wd_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
      end
   end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu with a 1-cycle-latency synchronous memory model.
module tb_mips_lsu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wd;
   logic [31:0] mem_rd;

   logic [31:0] mem [0:255];
   int          we_cnt = 0;
   int          n_chk = 0;
   int          n_fail = 0;

   mips_lsu #(.MEM_WORDS(128), .ADDR_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .mem_rd     (mem_rd)
   );

   always #5 clk = ~clk;

   // Single-port memory: synchronous write, read data one cycle after address.
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_wd;
      mem_rd <= mem[mem_addr];
   end

   always @(posedge clk) begin
      if (mem_we) we_cnt <= we_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Issue one request, wait (bounded) for the response and complete it.
   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err,
                         output int pulses);
      int c0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk);
      #1;
      c0        = we_cnt;
      req_valid = 1'b0;
      lat       = 1;
      while (lat <= 10) begin
         @(negedge clk);
         if (resp_valid) break;
         lat++;
      end
      rdata      = resp_rdata;
      err        = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      pulses     = we_cnt - c0;
   endtask

   task automatic run(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input logic [31:0] exp_rdata, input logic exp_err,
                      input int exp_pulses);
      int          lat, pulses;
      logic [31:0] rdata;
      logic        err;
      do_req(we, size, sgn, addr, wdata, lat, rdata, err, pulses);
      check({tag, ".lat"}, lat, exp_lat);
      check({tag, ".rdata"}, rdata, exp_rdata);
      check({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
      check({tag, ".we"}, pulses, exp_pulses);
   endtask

   initial begin
      int          c0, k;
      logic [31:0] held;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
      check("rst.resp_rdata", resp_rdata, 32'd0);
      check("rst.resp_err", {31'd0, resp_err}, 32'd0);
      check("rst.mem_we", {31'd0, mem_we}, 32'd0);
      check("rst.mem_addr", {24'd0, mem_addr}, 32'd0);
      check("rst.mem_wd", mem_wd, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst.req_ready", {31'd0, req_ready}, 32'd1);

      // 1: word store then word load
      run("t1.sw", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
      check("t1.mem4", mem[4], 32'hDEADBEEF);
      run("t1.lw", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 32'hDEADBEEF, 1'b0, 0);

      // 2: byte store read-modify-write, signed/unsigned byte load
      run("t2.init", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 2, 32'h0, 1'b0, 1);
      run("t2.sb", 1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 4, 32'h0, 1'b0, 1);
      check("t2.mem4", mem[4], 32'h11AA3344);
      run("t2.lb", 1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 3, 32'hFFFFFFAA, 1'b0, 0);
      run("t2.lbu", 1'b0, 2'b00, 1'b0, 32'h12, 32'h0, 3, 32'h000000AA, 1'b0, 0);
      run("t2.lbu0", 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 3, 32'h00000044, 1'b0, 0);

      // 3: upper half store, half and byte loads
      run("t3.init", 1'b1, 2'b10, 1'b0, 32'h1C, 32'h0, 2, 32'h0, 1'b0, 1);
      run("t3.sh", 1'b1, 2'b01, 1'b0, 32'h1E, 32'h0000BEEF, 4, 32'h0, 1'b0, 1);
      check("t3.mem7", mem[7], 32'hBEEF0000);
      run("t3.lh", 1'b0, 2'b01, 1'b1, 32'h1E, 32'h0, 3, 32'hFFFFBEEF, 1'b0, 0);
      run("t3.lhu", 1'b0, 2'b01, 1'b0, 32'h1E, 32'h0, 3, 32'h0000BEEF, 1'b0, 0);
      run("t3.lhlo", 1'b0, 2'b01, 1'b1, 32'h1C, 32'h0, 3, 32'h00000000, 1'b0, 0);
      run("t3.lbu3", 1'b0, 2'b00, 1'b0, 32'h1F, 32'h0, 3, 32'h000000BE, 1'b0, 0);

      // 4: errors
      run("t4.lw_mis", 1'b0, 2'b10, 1'b0, 32'h3, 32'h0, 1, 32'h0, 1'b1, 0);
      run("t4.sh_mis", 1'b1, 2'b01, 1'b0, 32'h5, 32'h1234, 1, 32'h0, 1'b1, 0);
      run("t4.sw_oor", 1'b1, 2'b10, 1'b0, 32'h200, 32'h1, 1, 32'h0, 1'b1, 0);
      run("t4.size3", 1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 1, 32'h0, 1'b1, 0);
      run("t4.lw_top", 1'b0, 2'b10, 1'b0, 32'h1FC, 32'h0, 3, mem[127], 1'b0, 0);
      check("t4.mem4", mem[4], 32'h11AA3344);

      // 5: response back-pressure; a pending request must wait
      run("t5.init", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_addr  = 32'h10;
      @(posedge clk);
      #1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      k = 0;
      while (k < 10 && !resp_valid) begin
         @(negedge clk);
         k++;
      end
      c0   = we_cnt;
      held = resp_rdata;
      check("t5.rdata", held, 32'hDEADBEEF);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("t5.hold_valid", {31'd0, resp_valid}, 32'd1);
         check("t5.hold_rdata", resp_rdata, 32'hDEADBEEF);
         check("t5.hold_ready", {31'd0, req_ready}, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      check("t5.idle", {31'd0, req_ready}, 32'd1);
      check("t5.no_we", we_cnt - c0, 32'd0);

      // 6: reset in WAIT of a byte store
      run("t6.init", 1'b1, 2'b10, 1'b0, 32'h14, 32'h55667788, 2, 32'h0, 1'b0, 1);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b00;
      req_addr  = 32'h14;
      req_wdata = 32'h99;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      c0 = we_cnt;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("t6.resp_valid", {31'd0, resp_valid}, 32'd0);
      check("t6.mem_we", {31'd0, mem_we}, 32'd0);
      check("t6.mem_addr", {24'd0, mem_addr}, 32'd0);
      check("t6.mem_wd", mem_wd, 32'd0);
      check("t6.resp_err", {31'd0, resp_err}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      check("t6.no_we", we_cnt - c0, 32'd0);
      check("t6.mem5", mem[5], 32'h55667788);
      run("t6.lw", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 3, 32'h55667788, 1'b0, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
